// File: rtl/spi_slave_drv.sv
// SPI register-access responder: a header word selects a write or read burst onto a clk_i register port.
// Defining SPI_SLAVE_ERRCNT_EN adds the saturating frame-error counter on err_cnt_o. DUMMY_NUM must be >= 1.
module spi_slave_drv #(
  parameter real TCQ        = 0.1,
  parameter int  PMT_SEL    = 0,
  parameter int  DUMMY_NUM  = 8,
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 16,
  parameter int  CMD_WIDTH  = 8,
  parameter int  SPI_MODE   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  SPI_CLK,
  input  logic                  SPI_CSN,
  input  logic [SPI_MODE-1:0]   SPI_MOSI,
  output logic [SPI_MODE-1:0]   SPI_MISO,
  output logic                  spi_miso_t_o,
  output logic                  reg_wr_vld_o,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wr_data_o,
  output logic                  reg_rd_req_o,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr_o,
  input  logic                  reg_rd_vld_i,
  input  logic [DATA_WIDTH-1:0] reg_rd_data_i,
  output logic [15:0]           err_cnt_o
);

  localparam int WORD_CYC = DATA_WIDTH / SPI_MODE;
  localparam int BC_W     = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
  localparam int DC_W     = (DUMMY_NUM > 1) ? $clog2(DUMMY_NUM) : 1;
  localparam int RX_W     = DATA_WIDTH - SPI_MODE;
  localparam logic [BC_W-1:0]       BC_LAST   = BC_W'(WORD_CYC - 1);
  localparam logic [DC_W-1:0]       DC_LAST   = DC_W'(DUMMY_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);
  localparam logic [7:0]            PMT_SEL8  = 8'(PMT_SEL);

  typedef enum logic [2:0] {IDLE, HDR, SKIP, WR_DATA, DUMMY, RD_DATA} state_t;

  // TCQ only shaped simulation timing in earlier models; it has no effect on this logic.
  if (TCQ < 0.0) begin : g_tcq_unused
  end

  logic [2:0]          sclk_sync_q, csn_sync_q;
  logic [SPI_MODE-1:0] mosi_s1_q, mosi_s2_q;

  state_t                state_q, state_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DC_W-1:0]       dum_cnt_q, dum_cnt_d;
  logic [4:0]            word_idx_q, word_idx_d, last_idx_q, last_idx_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [RX_W-1:0]       rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  wr_vld_q, wr_vld_d, rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  miso_t_q, miso_t_d;
  logic [1:0]            settle_q, settle_d;
  logic                  armed_q, armed_d;

  logic                  sclk_rise, sclk_fall, csn_fall, csn_rise;
  logic                  word_done, ld_word, last_word;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [7:0]            hdr_bsel;
  logic [4:0]            hdr_cnt;
  logic                  hdr_wr;

  // Bit 0 is the first sync stage, bit 1 the usable value, bit 2 its previous sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_q <= 3'b000;
      csn_sync_q  <= 3'b111;
      mosi_s1_q   <= '0;
      mosi_s2_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SPI_CLK};
      csn_sync_q  <= {csn_sync_q[1:0], SPI_CSN};
      mosi_s1_q   <= SPI_MOSI;
      mosi_s2_q   <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
  assign csn_fall  = armed_q & ~csn_sync_q[1] & csn_sync_q[2];

  assign rx_next   = {rx_sr_q, mosi_s2_q};
  assign hdr_addr  = rx_next[DATA_WIDTH-1 -: ADDR_WIDTH];
  assign hdr_bsel  = rx_next[CMD_WIDTH +: 8];
  assign hdr_wr    = rx_next[CMD_WIDTH-1];
  assign hdr_cnt   = rx_next[4:0];
  assign last_word = (word_idx_q == last_idx_q);
  assign word_done = sclk_rise && (bit_cnt_q == BC_LAST) &&
                     (state_q == HDR || state_q == WR_DATA || state_q == RD_DATA);
  assign ld_word   = (state_q == RD_DATA) && sclk_fall && (bit_cnt_q == '0);

  // The preset CSN=1 needs two clocks to flush; a frame only starts after CSN is genuinely seen high.
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & csn_sync_q[1]);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    dum_cnt_d  = dum_cnt_q;
    word_idx_d = word_idx_q;
    last_idx_d = last_idx_q;
    cur_addr_d = cur_addr_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    rd_buf_d   = rd_buf_q;
    rd_pend_d  = rd_pend_q;
    wr_vld_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;

    if (sclk_rise && (state_q == HDR || state_q == WR_DATA || state_q == RD_DATA)) begin
      bit_cnt_d = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + 1'b1;
      rx_sr_d   = rx_next[RX_W-1:0];
    end

    unique case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d   = HDR;
          bit_cnt_d = '0;
        end
      end
      HDR: begin
        if (word_done) begin
          word_idx_d = '0;
          last_idx_d = hdr_cnt;
          if (hdr_bsel != PMT_SEL8) begin
            state_d = SKIP;
          end else if (hdr_wr) begin
            state_d    = WR_DATA;
            cur_addr_d = hdr_addr;
          end else begin
            state_d    = DUMMY;
            dum_cnt_d  = '0;
            rd_req_d   = 1'b1;
            rd_addr_d  = hdr_addr;
            cur_addr_d = hdr_addr + ADDR_STEP;
          end
        end
      end
      WR_DATA: begin
        if (word_done) begin
          wr_vld_d   = 1'b1;
          wr_addr_d  = cur_addr_q;
          wr_data_d  = rx_next;
          cur_addr_d = cur_addr_q + ADDR_STEP;
          word_idx_d = word_idx_q + 1'b1;
          if (last_word) state_d = SKIP;
        end
      end
      DUMMY: begin
        if (sclk_rise) begin
          dum_cnt_d = dum_cnt_q + 1'b1;
          if (dum_cnt_q == DC_LAST) begin
            state_d   = RD_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      RD_DATA: begin
        // The falling edge opening each word loads fresh data and prefetches the next address.
        if (ld_word) begin
          tx_sr_d   = rd_pend_q ? rd_buf_q : '0;
          rd_pend_d = 1'b0;
          if (!last_word) begin
            rd_req_d   = 1'b1;
            rd_addr_d  = cur_addr_q;
            cur_addr_d = cur_addr_q + ADDR_STEP;
          end
        end else if (sclk_fall) begin
          tx_sr_d = tx_sr_q << SPI_MODE;
        end
        if (word_done) begin
          word_idx_d = word_idx_q + 1'b1;
          if (last_word) state_d = SKIP;
        end
      end
      default: ;
    endcase

    if (reg_rd_vld_i) begin
      rd_buf_d  = reg_rd_data_i;
      rd_pend_d = 1'b1;
    end
    if (csn_rise) state_d = IDLE;
    if (state_d != DUMMY && state_d != RD_DATA) tx_sr_d = '0;
    if (state_d == IDLE) begin
      rd_pend_d = 1'b0;
      bit_cnt_d = '0;
    end
    miso_t_d = !(state_d == DUMMY || state_d == RD_DATA);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      dum_cnt_q  <= '0;
      word_idx_q <= '0;
      last_idx_q <= '0;
      cur_addr_q <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rd_buf_q   <= '0;
      rd_pend_q  <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      miso_t_q   <= 1'b1;
      settle_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      dum_cnt_q  <= dum_cnt_d;
      word_idx_q <= word_idx_d;
      last_idx_q <= last_idx_d;
      cur_addr_q <= cur_addr_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      rd_buf_q   <= rd_buf_d;
      rd_pend_q  <= rd_pend_d;
      wr_vld_q   <= wr_vld_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      miso_t_q   <= miso_t_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
    end
  end

  assign SPI_MISO      = tx_sr_q[DATA_WIDTH-1 -: SPI_MODE];
  assign spi_miso_t_o  = miso_t_q;
  assign reg_wr_vld_o  = wr_vld_q;
  assign reg_wr_addr_o = wr_addr_q;
  assign reg_wr_data_o = wr_data_q;
  assign reg_rd_req_o  = rd_req_q;
  assign reg_rd_addr_o = rd_addr_q;

`ifdef SPI_SLAVE_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;
  logic        abort_evt, tmo_evt, frame_end;

  // A word that completes the whole burst on the same edge as CSN rise is a clean end, not an abort.
  assign frame_end = word_done && last_word && (state_q == WR_DATA || state_q == RD_DATA);
  assign abort_evt = csn_rise && !frame_end &&
                     (state_q == HDR || state_q == WR_DATA || state_q == DUMMY || state_q == RD_DATA);
  assign tmo_evt   = ld_word && !rd_pend_q;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 17'(abort_evt) + 17'(tmo_evt);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spi_slave_drv.sv
// Directed bench for spi_slave_drv: SPI master frames, register-side responder, logged strobes.
module tb_spi_slave_drv;

  localparam int HALF = 60;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        SPI_CLK = 1'b0;
  logic        SPI_CSN = 1'b1;
  logic [1:0]  SPI_MOSI = 2'b00;
  logic [1:0]  SPI_MISO;
  logic        spi_miso_t_o;
  logic        reg_wr_vld_o;
  logic [15:0] reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;
  logic        reg_rd_req_o;
  logic [15:0] reg_rd_addr_o;
  logic        reg_rd_vld_i;
  logic [31:0] reg_rd_data_i;
  logic [15:0] err_cnt_o;

  spi_slave_drv dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .SPI_CLK      (SPI_CLK),
    .SPI_CSN      (SPI_CSN),
    .SPI_MOSI     (SPI_MOSI),
    .SPI_MISO     (SPI_MISO),
    .spi_miso_t_o (spi_miso_t_o),
    .reg_wr_vld_o (reg_wr_vld_o),
    .reg_wr_addr_o(reg_wr_addr_o),
    .reg_wr_data_o(reg_wr_data_o),
    .reg_rd_req_o (reg_rd_req_o),
    .reg_rd_addr_o(reg_rd_addr_o),
    .reg_rd_vld_i (reg_rd_vld_i),
    .reg_rd_data_i(reg_rd_data_i),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Register-side activity log, sampled on the falling clk edge.
  logic [15:0] wr_a_log[$];
  logic [31:0] wr_d_log[$];
  logic [15:0] rd_a_log[$];
  int          both_cnt = 0;
  int          t_low_cnt = 0;

  always @(negedge clk_i) begin
    if (reg_wr_vld_o) begin
      wr_a_log.push_back(reg_wr_addr_o);
      wr_d_log.push_back(reg_wr_data_o);
    end
    if (reg_rd_req_o) rd_a_log.push_back(reg_rd_addr_o);
    if (reg_wr_vld_o && reg_rd_req_o) both_cnt++;
    if (!spi_miso_t_o) t_low_cnt++;
  end

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0010: mem_val = 32'h11223344;
      16'h0014: mem_val = 32'h55667788;
      16'h0018: mem_val = 32'h99AABBCC;
      default:  mem_val = 32'hFFFFFFFF;
    endcase
  endfunction

  // Register responder: returns data two clocks after each request while enabled.
  bit          resp_en = 1'b1;
  logic [15:0] resp_addr;
  initial begin : responder
    reg_rd_vld_i  = 1'b0;
    reg_rd_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (reg_rd_req_o && resp_en) begin
        resp_addr = reg_rd_addr_o;
        repeat (2) @(negedge clk_i);
        reg_rd_vld_i  = 1'b1;
        reg_rd_data_i = mem_val(resp_addr);
        @(negedge clk_i);
        reg_rd_vld_i  = 1'b0;
      end
    end
  end

  task automatic spi_bits(input logic [31:0] tx, input int ncyc, output logic [31:0] rx);
    logic [31:0] sh;
    sh = tx;
    rx = '0;
    for (int i = 0; i < ncyc; i++) begin
      SPI_MOSI = sh[31:30];
      sh = sh << 2;
      #HALF;
      rx = {rx[29:0], SPI_MISO};
      SPI_CLK = 1'b1;
      #HALF;
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic csn_lo();
    SPI_CSN = 1'b0;
    #HALF;
  endtask

  task automatic csn_hi();
    #HALF;
    SPI_CSN  = 1'b1;
    SPI_MOSI = 2'b00;
    #(4 * HALF);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rx;
    logic [31:0] exp_rd [3];
    int wb, rb, tl;
    int exp_err;
    exp_err = 0;
    exp_rd[0] = 32'h11223344;
    exp_rd[1] = 32'h55667788;
    exp_rd[2] = 32'h99AABBCC;

    repeat (3) @(negedge clk_i);
    check_val("rst.wr_vld",  32'(reg_wr_vld_o),  32'h0);
    check_val("rst.rd_req",  32'(reg_rd_req_o),  32'h0);
    check_val("rst.wr_addr", 32'(reg_wr_addr_o), 32'h0);
    check_val("rst.wr_data", reg_wr_data_o,      32'h0);
    check_val("rst.rd_addr", 32'(reg_rd_addr_o), 32'h0);
    check_val("rst.miso",    32'(SPI_MISO),      32'h0);
    check_val("rst.miso_t",  32'(spi_miso_t_o),  32'h1);
    check_val("rst.err",     32'(err_cnt_o),     32'h0);
    rst_n_i = 1'b1;
    repeat (6) @(negedge clk_i);

    // Two-word write burst
    wb = wr_a_log.size(); rb = rd_a_log.size(); tl = t_low_cnt;
    csn_lo();
    spi_bits(32'h4000_0081, 16, rx);
    spi_bits(32'h0123_4567, 16, rx);
    spi_bits(32'h89AB_CDEF, 16, rx);
    csn_hi();
    check_val("wr.count", 32'(wr_a_log.size() - wb), 32'd2);
    if (wr_a_log.size() >= wb + 2) begin
      check_val("wr.addr0", 32'(wr_a_log[wb]),     32'h4000);
      check_val("wr.data0", wr_d_log[wb],          32'h0123_4567);
      check_val("wr.addr1", 32'(wr_a_log[wb + 1]), 32'h4004);
      check_val("wr.data1", wr_d_log[wb + 1],      32'h89AB_CDEF);
    end
    check_val("wr.no_rd_req", 32'(rd_a_log.size() - rb), 32'd0);
    check_val("wr.miso_t_low", 32'(t_low_cnt - tl), 32'd0);

    // Three-word read burst
    wb = wr_a_log.size(); rb = rd_a_log.size();
    csn_lo();
    spi_bits(32'h0010_0002, 15, rx);
    check_val("rd.t_hdr", 32'(spi_miso_t_o), 32'h1);
    spi_bits(32'h0000_0002 << 30, 1, rx);
    spi_bits(32'h0, 4, rx);
    check_val("rd.t_dummy", 32'(spi_miso_t_o), 32'h0);
    check_val("rd.miso_dummy", 32'(SPI_MISO), 32'h0);
    spi_bits(32'h0, 4, rx);
    for (int k = 0; k < 3; k++) begin
      spi_bits(32'h0, 16, rx);
      check_val($sformatf("rd.word%0d", k), rx, exp_rd[k]);
    end
    repeat (4) @(negedge clk_i);
    check_val("rd.t_after", 32'(spi_miso_t_o), 32'h1);
    csn_hi();
    check_val("rd.req_count", 32'(rd_a_log.size() - rb), 32'd3);
    if (rd_a_log.size() >= rb + 3) begin
      check_val("rd.req0", 32'(rd_a_log[rb]),     32'h0010);
      check_val("rd.req1", 32'(rd_a_log[rb + 1]), 32'h0014);
      check_val("rd.req2", 32'(rd_a_log[rb + 2]), 32'h0018);
    end
    check_val("rd.no_wr", 32'(wr_a_log.size() - wb), 32'd0);

    // Header for another board: ignored entirely
    wb = wr_a_log.size(); rb = rd_a_log.size(); tl = t_low_cnt;
    csn_lo();
    spi_bits(32'h4000_0581, 16, rx);
    spi_bits(32'hCAFE_F00D, 16, rx);
    spi_bits(32'h1357_9BDF, 16, rx);
    csn_hi();
    check_val("skip.wr", 32'(wr_a_log.size() - wb), 32'd0);
    check_val("skip.rd", 32'(rd_a_log.size() - rb), 32'd0);
    check_val("skip.miso_t_low", 32'(t_low_cnt - tl), 32'd0);

    // Write aborted after 20 data bits
    wb = wr_a_log.size();
    csn_lo();
    spi_bits(32'h4000_0080, 16, rx);
    spi_bits(32'h1234_5678, 10, rx);
    csn_hi();
`ifdef SPI_SLAVE_ERRCNT_EN
    exp_err++;
`endif
    check_val("abort.no_wr", 32'(wr_a_log.size() - wb), 32'd0);
    check_val("abort.err", 32'(err_cnt_o), 32'(exp_err));

    // Read with no data returned: zeros and a timeout
    resp_en = 1'b0;
    rb = rd_a_log.size();
    csn_lo();
    spi_bits(32'h0020_0000, 16, rx);
    spi_bits(32'h0, 8, rx);
    spi_bits(32'h0, 16, rx);
    check_val("tmo.word", rx, 32'h0);
    csn_hi();
    resp_en = 1'b1;
`ifdef SPI_SLAVE_ERRCNT_EN
    exp_err++;
`endif
    check_val("tmo.req_count", 32'(rd_a_log.size() - rb), 32'd1);
    if (rd_a_log.size() >= rb + 1) check_val("tmo.req0", 32'(rd_a_log[rb]), 32'h0020);
    check_val("tmo.err", 32'(err_cnt_o), 32'(exp_err));

    // Reset pulse in the middle of a write burst
    wb = wr_a_log.size();
    csn_lo();
    spi_bits(32'h4000_0081, 16, rx);
    spi_bits(32'h0123_4567, 6, rx);
    rst_n_i = 1'b0;
    #1;
    exp_err = 0;
    check_val("mrst.wr_vld",  32'(reg_wr_vld_o),  32'h0);
    check_val("mrst.wr_addr", 32'(reg_wr_addr_o), 32'h0);
    check_val("mrst.wr_data", reg_wr_data_o,      32'h0);
    check_val("mrst.rd_addr", 32'(reg_rd_addr_o), 32'h0);
    check_val("mrst.miso_t",  32'(spi_miso_t_o),  32'h1);
    check_val("mrst.err",     32'(err_cnt_o),     32'h0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    spi_bits(32'h0123_4567 << 12, 10, rx);
    spi_bits(32'h89AB_CDEF, 16, rx);
    csn_hi();
    check_val("mrst.no_wr", 32'(wr_a_log.size() - wb), 32'd0);

    // Full frame after reset, with address wrap-around
    wb = wr_a_log.size();
    csn_lo();
    spi_bits(32'hFFFC_0081, 16, rx);
    spi_bits(32'hDEAD_BEEF, 16, rx);
    spi_bits(32'h0BAD_F00D, 16, rx);
    csn_hi();
    check_val("wrap.count", 32'(wr_a_log.size() - wb), 32'd2);
    if (wr_a_log.size() >= wb + 2) begin
      check_val("wrap.addr0", 32'(wr_a_log[wb]),     32'hFFFC);
      check_val("wrap.data0", wr_d_log[wb],          32'hDEAD_BEEF);
      check_val("wrap.addr1", 32'(wr_a_log[wb + 1]), 32'h0000);
      check_val("wrap.data1", wr_d_log[wb + 1],      32'h0BAD_F00D);
    end
    check_val("wrap.err", 32'(err_cnt_o), 32'(exp_err));
    check_val("excl.wr_rd", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
